// File: rtl/sdm_ctrl_pkg.sv
// rtl/sdm_ctrl_pkg.sv - shared types, constants and slew helper for the SDM sample scheduler
//
// Purpose : scheduler state encoding, sample width and the saturating
//           slew-to-zero step shared by the scheduler RTL.
// Contents: state_e, SAMPLE_W, slew_to_zero()
package sdm_ctrl_pkg;

   localparam int SAMPLE_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      STOP  = 2'd3
   } state_e;

   // One slew step toward zero. Done in SAMPLE_W+1 bits so that -32768
   // plus a step, and the negated step itself, never wrap. A magnitude at
   // or below the step lands exactly on zero (no overshoot).
   function automatic logic signed [SAMPLE_W-1:0] slew_to_zero(
      input logic signed [SAMPLE_W-1:0] sample,
      input logic        [SAMPLE_W-1:0] step
   );
      logic signed [SAMPLE_W:0] s_ext;
      logic signed [SAMPLE_W:0] st_ext;
      logic signed [SAMPLE_W:0] res;
      s_ext  = {sample[SAMPLE_W-1], sample};
      st_ext = {1'b0, step};
      res    = '0;
      if (s_ext > st_ext) begin
         res = s_ext - st_ext;
      end else if (s_ext < -st_ext) begin
         res = s_ext + st_ext;
      end
      return res[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/sdm_sample_fifo.sv
// rtl/sdm_sample_fifo.sv - synchronous sample FIFO with flush and level
//
// Purpose : small power-of-two FIFO buffering PCM samples.
// Ports   : clk, reset_n (sync, active-low)
//           push/wdata   - write when not full
//           pop          - read when not empty
//           flush        - empty the FIFO (wins over push/pop)
//           rdata        - head entry, combinational
//           full, empty, level - registered occupancy
module sdm_sample_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         // Simultaneous push and pop leaves the level unchanged.
         if (do_push && !do_pop) begin
            level_q <= level_q + 1'b1;
         end else if (do_pop && !do_push) begin
            level_q <= level_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdm_sample_scheduler.sv
// rtl/sdm_sample_scheduler.sv - paces buffered PCM samples into the sigma-delta modulator
//
// Purpose : buffers input samples and presents one to the modulator every
//           OSR clocks; sequences modulator reset, priming, soft mute,
//           underflow recovery and a ramped stop.
// Ports   : clk, reset_n (sync, active-low)
//           enable, mute, clear_status     - control levels / pulse
//           s_valid, s_data, s_ready       - sample input handshake
//           mod_sample, mod_sample_stb     - modulator sample and update strobe
//           mod_reset                      - modulator reset (active-high)
//           underflow                      - sticky starvation flag
//           fifo_level, busy               - status
module sdm_sample_scheduler
   import sdm_ctrl_pkg::*;
#(
   parameter int OSR         = 128,
   parameter int FIFO_DEPTH  = 4,
   parameter int PRIME_LEVEL = 2,
   parameter int RAMP_STEP   = 512
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            enable,
   input  logic                            mute,
   input  logic                            clear_status,
   input  logic                            s_valid,
   input  logic [SAMPLE_W-1:0]             s_data,
   output logic                            s_ready,
   output logic [SAMPLE_W-1:0]             mod_sample,
   output logic                            mod_sample_stb,
   output logic                            mod_reset,
   output logic                            underflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
   output logic                            busy
);

   localparam int                     CW        = (OSR > 1) ? $clog2(OSR) : 1;
   localparam int                     LW        = $clog2(FIFO_DEPTH+1);
   localparam logic [LW-1:0]          PRIME_LVL = LW'(PRIME_LEVEL);
   localparam logic [SAMPLE_W-1:0]    STEP      = SAMPLE_W'(RAMP_STEP);

   state_e                      state_q, state_d;
   logic [CW-1:0]               osr_cnt_q, osr_cnt_d;
   logic signed [SAMPLE_W-1:0]  sample_q, sample_d;
   logic                        stb_q, stb_d;
   logic                        underflow_q, underflow_d;

   logic                        tick;
   logic                        fifo_push;
   logic                        fifo_pop;
   logic                        fifo_flush;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [SAMPLE_W-1:0]         fifo_head;
   logic [LW-1:0]               fifo_level_w;
   logic                        uf_set;
   logic signed [SAMPLE_W-1:0]  slewed;

   sdm_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (fifo_flush),
      .wdata   (s_data),
      .rdata   (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level_w)
   );

   // Ready depends only on registered state, never on s_valid or a pop.
   assign s_ready        = !fifo_full && (state_q == PRIME || state_q == RUN);
   assign fifo_push      = s_valid && s_ready;
   assign tick           = (osr_cnt_q == '0);
   assign slewed         = slew_to_zero(sample_q, STEP);

   assign mod_sample     = sample_q;
   assign mod_sample_stb = stb_q;
   assign mod_reset      = (state_q == IDLE) || (state_q == PRIME);
   assign underflow      = underflow_q;
   assign fifo_level     = fifo_level_w;
   assign busy           = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      osr_cnt_d  = (osr_cnt_q == CW'(OSR-1)) ? '0 : osr_cnt_q + 1'b1;
      sample_d   = sample_q;
      stb_d      = 1'b0;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;
      uf_set     = 1'b0;

      case (state_q)
         IDLE: begin
            fifo_flush = 1'b1;
            osr_cnt_d  = '0;
            if (enable) begin
               state_d = PRIME;
            end
         end
         PRIME: begin
            // Held at zero so the first RUN cycle is a tick.
            osr_cnt_d = '0;
            if (!enable) begin
               state_d    = IDLE;
               fifo_flush = 1'b1;
            end else if (fifo_level_w >= PRIME_LVL) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (tick) begin
               stb_d = 1'b1;
               if (mute) begin
                  // Muted ticks still consume input to keep the source paced.
                  fifo_pop = !fifo_empty;
                  sample_d = slewed;
               end else if (fifo_empty) begin
                  uf_set   = 1'b1;
                  sample_d = slewed;
               end else begin
                  fifo_pop = 1'b1;
                  sample_d = fifo_head;
               end
            end
            if (!enable) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               if (sample_q == '0) begin
                  state_d    = IDLE;
                  fifo_flush = 1'b1;
                  osr_cnt_d  = '0;
               end else begin
                  stb_d    = 1'b1;
                  sample_d = slewed;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A same-cycle set beats clear_status.
      underflow_d = uf_set || (underflow_q && !clear_status);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         osr_cnt_q   <= '0;
         sample_q    <= '0;
         stb_q       <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         osr_cnt_q   <= osr_cnt_d;
         sample_q    <= sample_d;
         stb_q       <= stb_d;
         underflow_q <= underflow_d;
      end
   end

endmodule

// File: tb/tb_sdm_sample_scheduler.sv
// tb/tb_sdm_sample_scheduler.sv - self-checking bench for sdm_sample_scheduler
module tb_sdm_sample_scheduler;

   localparam int OSR  = 8;
   localparam int DEP  = 4;
   localparam int PRL  = 2;
   localparam int STEP = 512;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        mute;
   logic        clear_status;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_ready;
   logic [15:0] mod_sample;
   logic        mod_sample_stb;
   logic        mod_reset;
   logic        underflow;
   logic [2:0]  fifo_level;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sdm_sample_scheduler #(
      .OSR         (OSR),
      .FIFO_DEPTH  (DEP),
      .PRIME_LEVEL (PRL),
      .RAMP_STEP   (STEP)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .enable         (enable),
      .mute           (mute),
      .clear_status   (clear_status),
      .s_valid        (s_valid),
      .s_data         (s_data),
      .s_ready        (s_ready),
      .mod_sample     (mod_sample),
      .mod_sample_stb (mod_sample_stb),
      .mod_reset      (mod_reset),
      .underflow      (underflow),
      .fifo_level     (fifo_level),
      .busy           (busy)
   );

   typedef struct {
      logic        push;
      logic [15:0] data;
      logic        mute;
      logic [15:0] exp_sample;
      logic        exp_uf;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the sample was accepted.
   task automatic push(input logic [15:0] d);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = d;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("push_timeout", 32'(s_ready), 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // Returns at the negedge where the strobe is visible; n = negedges waited.
   task automatic wait_stb(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mod_sample_stb && n < 64);
      if (!mod_sample_stb) check("stb_timeout", 32'(mod_sample_stb), 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_s_ready"},   32'(s_ready),        32'd0);
      check({tag, "_sample"},    32'(mod_sample),     32'd0);
      check({tag, "_stb"},       32'(mod_sample_stb), 32'd0);
      check({tag, "_mod_reset"}, 32'(mod_reset),      32'd1);
      check({tag, "_underflow"}, 32'(underflow),      32'd0);
      check({tag, "_level"},     32'(fifo_level),     32'd0);
      check({tag, "_busy"},      32'(busy),           32'd0);
   endtask

   logic [15:0] stream [32];

   initial begin
      int n;
      logic [15:0] exp_s;

      //               push  data      mute  expected  uf
      vecs[0]  = '{1'b1, 16'h0700, 1'b0, 16'h0700, 1'b0};
      vecs[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0500, 1'b1};
      vecs[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0300, 1'b1};
      vecs[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0100, 1'b1};
      vecs[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
      vecs[5]  = '{1'b1, 16'h1234, 1'b0, 16'h1234, 1'b1};
      vecs[6]  = '{1'b1, 16'h8000, 1'b0, 16'h8000, 1'b1};
      vecs[7]  = '{1'b1, 16'h7FFF, 1'b1, 16'h8200, 1'b1};
      vecs[8]  = '{1'b1, 16'h0111, 1'b1, 16'h8400, 1'b1};
      vecs[9]  = '{1'b1, 16'h0222, 1'b0, 16'h0222, 1'b1};
      vecs[10] = '{1'b1, 16'hFE00, 1'b0, 16'hFE00, 1'b1};
      vecs[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
      vecs[12] = '{1'b1, 16'hFD00, 1'b0, 16'hFD00, 1'b1};
      vecs[13] = '{1'b0, 16'h0000, 1'b0, 16'hFF00, 1'b1};
      vecs[14] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
      vecs[15] = '{1'b1, 16'h0200, 1'b0, 16'h0200, 1'b1};
      vecs[16] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};

      for (int i = 0; i < 32; i++) stream[i] = 16'(16'h0A00 + i * 16'h0103);

      reset_n = 1'b0; enable = 1'b0; mute = 1'b0; clear_status = 1'b0;
      s_valid = 1'b0; s_data = '0;

      // Reset state
      @(negedge clk);
      check_reset_values("rst");
      reset_n = 1'b1;

      // Start-up priming and first two samples
      enable = 1'b1;
      @(negedge clk);
      check("prime_busy", 32'(busy), 32'd1);
      check("prime_ready", 32'(s_ready), 32'd1);
      check("prime_mod_reset", 32'(mod_reset), 32'd1);
      push(16'h1000);
      push(16'h2000);
      wait_stb(n);
      check("first_sample", 32'(mod_sample), 32'h1000);
      check("run_mod_reset", 32'(mod_reset), 32'd0);
      wait_stb(n);
      check("tick_period", 32'(n), 32'(OSR));
      check("second_sample", 32'(mod_sample), 32'h2000);

      // Table: one tick per record, FIFO empty at the start of each
      for (int i = 0; i < 17; i++) begin
         mute = vecs[i].mute;
         if (vecs[i].push) push(vecs[i].data);
         wait_stb(n);
         check($sformatf("vec%0d_sample", i), 32'(mod_sample), 32'(vecs[i].exp_sample));
         check($sformatf("vec%0d_uf", i), 32'(underflow), 32'(vecs[i].exp_uf));
         check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'd0);
      end
      mute = 1'b0;

      // clear_status without a concurrent set
      clear_status = 1'b1;
      @(negedge clk);
      clear_status = 1'b0;
      check("clear_uf", 32'(underflow), 32'd0);
      // clear_status on a starving tick: set wins
      wait_stb(n);
      repeat (OSR - 1) @(negedge clk);
      clear_status = 1'b1;
      @(negedge clk);
      clear_status = 1'b0;
      check("set_beats_clear_stb", 32'(mod_sample_stb), 32'd1);
      check("set_beats_clear_uf", 32'(underflow), 32'd1);

      // Fill to full between ticks, then 32 samples at steady rate
      wait_stb(n);
      clear_status = 1'b1;
      @(negedge clk);
      clear_status = 1'b0;
      check("clear_again_uf", 32'(underflow), 32'd0);
      fork
         begin
            for (int i = 0; i < 32; i++) begin
               push(stream[i]);
               if (i == 3) begin
                  check("full_ready", 32'(s_ready), 32'd0);
                  check("full_level", 32'(fifo_level), 32'd4);
               end
            end
         end
         begin
            for (int j = 0; j < 32; j++) begin
               int m;
               wait_stb(m);
               check($sformatf("stream%0d", j), 32'(mod_sample), 32'(stream[j]));
            end
         end
      join
      check("stream_no_uf", 32'(underflow), 32'd0);

      // Ramped stop
      push(16'h0300);
      push(16'h0555);
      wait_stb(n);
      check("stop_pre_sample", 32'(mod_sample), 32'h0300);
      enable = 1'b0;
      @(negedge clk);
      check("stop_ready", 32'(s_ready), 32'd0);
      check("stop_busy", 32'(busy), 32'd1);
      check("stop_level_held", 32'(fifo_level), 32'd1);
      wait_stb(n);
      check("stop_ramp1", 32'(mod_sample), 32'h0100);
      wait_stb(n);
      check("stop_ramp2", 32'(mod_sample), 32'h0000);
      repeat (OSR) @(negedge clk);
      check("stop_idle_mod_reset", 32'(mod_reset), 32'd1);
      check("stop_idle_level", 32'(fifo_level), 32'd0);
      check("stop_idle_busy", 32'(busy), 32'd0);

      // Soft mute from full-scale negative
      enable = 1'b1;
      @(negedge clk);
      push(16'h8000);
      push(16'h1111);
      wait_stb(n);
      check("mute_start", 32'(mod_sample), 32'h8000);
      mute = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         push(16'(16'h4000 + k));
         wait_stb(n);
         exp_s = (k < 64) ? 16'(-32768 + STEP * k) : 16'h0000;
         check($sformatf("mute_tick%0d", k), 32'(mod_sample), 32'(exp_s));
         check($sformatf("mute_level%0d", k), 32'(fifo_level), 32'd1);
      end
      mute = 1'b0;
      wait_stb(n);
      check("unmute_direct", 32'(mod_sample), 32'h4040);

      // Reset in RUN with a full FIFO
      push(16'hA001);
      push(16'hA002);
      push(16'hA003);
      push(16'hA004);
      check("prereset_full", 32'(fifo_level), 32'd4);
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("glitch_level", 32'(fifo_level), 32'd4);
      check("glitch_busy", 32'(busy), 32'd1);
      check("glitch_sample", 32'(mod_sample), 32'h4040);
      reset_n = 1'b0;
      @(negedge clk);
      check_reset_values("midrun_rst");
      reset_n = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sdm_sample_scheduler.md
Name: sdm_sample_scheduler

Overview:
Rate controller in front of the second-order sigma-delta modulator. It buffers 16-bit PCM samples from the interpolating filter through a valid/ready interface, and presents one sample to the modulator every OSR modulator clocks. It sequences modulator reset, start-up priming, soft mute, underflow recovery and a click-free stop. It runs entirely in the 128x modulator clock domain.

Parameters:
OSR, 128, modulator clocks per input sample (>=2)
FIFO_DEPTH, 4, sample buffer depth (power of 2, >=2)
PRIME_LEVEL, 2, FIFO fill level required before leaving PRIME (1..FIFO_DEPTH)
RAMP_STEP, 512, magnitude step per sample tick when slewing toward zero (unsigned, 1..32767)

Ports:
clk  in  1  modulator clock (128x)
reset_n  in  1  reset, synchronous, active-low
enable  in  1  level; 1 = run the modulator path, 0 = stop
mute  in  1  level; soft mute request
clear_status  in  1  pulse; clears the sticky underflow flag
s_valid  in  1  input sample valid
s_data  in  16  input sample, signed two's complement
s_ready  out  1  FIFO can accept a sample
mod_sample  out  16  signed sample driving the modulator input
mod_sample_stb  out  1  one-cycle pulse; mod_sample was updated this cycle
mod_reset  out  1  active-high reset to the modulator
underflow  out  1  sticky; FIFO was empty at a tick while running and unmuted
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, FIFO flushed.
  - Outputs: s_ready=0, mod_sample=0, mod_sample_stb=0, mod_reset=1, underflow=0, fifo_level=0, busy=0.
  - Reset mid-operation aborts immediately; no ramp.
- Push: occurs when s_valid && s_ready.
  - s_ready = !full, and only in PRIME or RUN.
  - s_ready does not depend on s_valid or on a same-cycle pop.
- IDLE: mod_reset=1, FIFO held empty. enable=1 -> PRIME.
- PRIME:
  - mod_reset=1, pushes accepted.
  - fifo_level>=PRIME_LEVEL -> RUN. osr_cnt is cleared on this transition.
  - enable=0 -> IDLE, with FIFO flush.
- RUN:
  - mod_reset=0. osr_cnt counts 0..OSR-1 and wraps.
  - A tick is osr_cnt==0, so the first tick is the first RUN cycle. Tick period is exactly OSR clocks.
  - At a tick, priority order:
    - mute=1: pop the head and discard it if the FIFO is not empty; slew mod_sample toward 0.
    - FIFO empty: no pop; set underflow; slew toward 0.
    - Otherwise: pop and load mod_sample = head directly.
  - mod_sample_stb=1 for the tick cycle+1, i.e. the first cycle the new value is visible. It pulses every tick even if the value is unchanged.
  - enable=0 -> STOP. This is sampled every cycle, not only at ticks.
- STOP:
  - s_ready=0, no pops, osr_cnt keeps running.
  - Each tick slews toward 0.
  - mod_sample==0 at a tick -> IDLE, with FIFO flush and mod_reset=1 on the next cycle.
  - enable=1 during STOP is ignored until IDLE is reached.
- Slew toward 0, computed in 17-bit signed arithmetic:
  - mod_sample > RAMP_STEP: subtract RAMP_STEP.
  - mod_sample < -RAMP_STEP: add RAMP_STEP.
  - Otherwise: result is 0.
  - No overshoot. -32768 is handled without overflow.
- Unmute or underflow recovery: the next tick with data loads the head directly, with no upward ramp.
- Simultaneous push and pop when not full: both occur, and the level is unchanged.
- Push while full is impossible because s_ready=0.
- underflow: set has priority over a same-cycle clear_status. Only reset or clear_status clear it.
- fifo_level and busy are registered state, with no combinational input paths.

Decomposition:
- Shared package sdm_ctrl_pkg:
  - state enum {IDLE, PRIME, RUN, STOP}.
  - Sample width constant SAMPLE_W=16.
  - Function for the saturating slew-to-zero step.
- One sub-module, sdm_sample_fifo:
  - Synchronous FIFO with push/pop/flush, full/empty, level, and head data visible combinationally.
  - Parameterised by depth and width.
- The scheduler FSM, OSR counter and output registers live in the top.

Test Plan:
1. Reset, then enable=1, then push 0x1000 and 0x2000 (OSR=8, PRIME_LEVEL=2) -> mod_reset falls the cycle after the second push; mod_sample=0x1000 with stb, then 0x2000 with stb exactly 8 clocks later.
2. Hold s_valid=1 with FIFO_DEPTH=4 and no ticks yet -> s_ready=0 after 4 accepted pushes and fifo_level=4; no sample lost or duplicated across 32 samples at steady rate.
3. In RUN with mod_sample=0x0700, starve the FIFO -> underflow=1; at successive ticks mod_sample reads 0x0500, 0x0300, 0x0100, 0x0000. clear_status drops the flag unless a same-cycle set occurs.
4. mute=1 with mod_sample=-32768 and RAMP_STEP=512 -> 64 ticks to reach 0 with no wrap; the FIFO still drains one sample per tick. On release, the next tick loads the head value directly.
5. enable=0 in RUN at mod_sample=0x0300 -> STOP; s_ready=0; ticks give 0x0100, then 0. The next tick (value 0) enters IDLE, with mod_reset=1 and fifo_level=0.
6. reset_n=0 mid-RUN with a full FIFO -> on the next edge all outputs take their reset values. Asynchronous reset_n pulses not spanning a clk edge have no effect.
